// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
//   Two-street traffic light controller with an optional pedestrian phase.
//   All timing is counted in ticks from a free-running prescaler. The phase
//   FSM only moves on tick cycles. The lamp outputs are registered decodes of
//   the state.
//
//   Optional feature macro: PED_CROSS_EN
//     When it is defined, the design adds the ped_req input, the walk output,
//     the PED_WALK phase and the pending-pedestrian latch.
//     When it is undefined, ped_pending is constant 0 and PED_WALK is never
//     entered.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous reset, active low
//   ta, tb   in   traffic present on street A / B (asynchronous pins)
//   ped_req  in   pedestrian button, asynchronous (PED_CROSS_EN only)
//   la, lb   out  street lights: 00 green, 01 yellow, 10 red
//   walk     out  pedestrian walk lamp (PED_CROSS_EN only)
//   tick     out  one-cycle pulse per timing tick
//   state    out  current phase code (0..6)
// -----------------------------------------------------------------------------
module intersection_scheduler #(
    parameter int TICK_DIV  = 16000000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ta,
    input  logic       tb,
`ifdef PED_CROSS_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic       tick,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        A_GREEN   = 3'd0,
        A_YELLOW  = 3'd1,
        ALLRED_AB = 3'd2,
        B_GREEN   = 3'd3,
        B_YELLOW  = 3'd4,
        ALLRED_BA = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic [1:0] L_GRN = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_RED = 2'b10;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    // The dwell timer saturates at GREEN_MAX. If a configured phase is longer
    // than GREEN_MAX, the timer saturates at that phase length instead, so
    // the phase can still end.
    localparam int TSAT_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int TSAT_B = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int TSAT   = (TSAT_A > TSAT_B) ? TSAT_A : TSAT_B;
    localparam int TW     = $clog2(TSAT + 1);
    localparam logic [TW-1:0] T_SAT = TW'(TSAT);

    // A phase of length len ends on the tick on which the number of ticks
    // spent in it, counting this tick, reaches len (that is, timer >= len-1).
    function automatic logic phase_done(input logic [TW-1:0] t, input int len);
        return (int'(t) + 1) >= len;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [1:0] ta_sync_q, tb_sync_q;
    logic       ta_s, tb_s;
    logic       ped_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ta_sync_q <= '0;
            tb_sync_q <= '0;
        end else begin
            ta_sync_q <= {ta_sync_q[0], ta};
            tb_sync_q <= {tb_sync_q[0], tb};
        end
    end

    assign ta_s = ta_sync_q[1];
    assign tb_s = tb_sync_q[1];

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_w;

    assign tick_w  = (presc_q == PRE_LAST);
    assign presc_d = tick_w ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    assign tick = tick_w;

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          walk_from_b_q, walk_from_b_d;
    logic          entering_walk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= A_GREEN;
            timer_q       <= '0;
            walk_from_b_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            walk_from_b_q <= walk_from_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick_w) begin
            case (state_q)
                A_GREEN:
                    if (phase_done(timer_q, GREEN_MIN) && (tb_s || ped_pend) &&
                        (!ta_s || phase_done(timer_q, GREEN_MAX)))
                        state_d = A_YELLOW;
                A_YELLOW:
                    if (phase_done(timer_q, YELLOW_T)) state_d = ALLRED_AB;
                ALLRED_AB:
                    if (phase_done(timer_q, ALLRED_T))
                        state_d = ped_pend ? PED_WALK : B_GREEN;
                B_GREEN:
                    if (phase_done(timer_q, GREEN_MIN) && (ta_s || ped_pend) &&
                        (!tb_s || phase_done(timer_q, GREEN_MAX)))
                        state_d = B_YELLOW;
                B_YELLOW:
                    if (phase_done(timer_q, YELLOW_T)) state_d = ALLRED_BA;
                ALLRED_BA:
                    if (phase_done(timer_q, ALLRED_T))
                        state_d = ped_pend ? PED_WALK : A_GREEN;
                PED_WALK:
                    // After the walk, serve the street opposite the last green.
                    if (phase_done(timer_q, WALK_T))
                        state_d = walk_from_b_q ? A_GREEN : B_GREEN;
                default: state_d = A_GREEN;
            endcase
        end
    end

    assign entering_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

    always_comb begin
        walk_from_b_d = walk_from_b_q;
        if (entering_walk) walk_from_b_d = (state_q == ALLRED_BA);
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)              timer_d = '0;
        else if (tick_w && timer_q != T_SAT) timer_d = timer_q + TW'(1);
    end

    // ------------------------------------------------------------------
    // Pedestrian request latch
    // ------------------------------------------------------------------
`ifdef PED_CROSS_EN
    logic [1:0] ped_sync_q;
    logic       ped_pend_q, ped_pend_d;
    logic       walk_q, walk_d;

    // Entering the walk phase consumes the request. A press during the walk
    // sets the latch again, so it is served at the next all-red.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (entering_walk)      ped_pend_d = 1'b0;
        else if (ped_sync_q[1]) ped_pend_d = 1'b1;
    end

    assign walk_d = (state_d == PED_WALK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_sync_q <= '0;
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            ped_sync_q <= {ped_sync_q[0], ped_req};
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
        end
    end

    assign ped_pend = ped_pend_q;
    assign walk     = walk_q;
`else
    assign ped_pend = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered lamp decode. It is taken from state_d so that the lamps
    // change on the same edge as state_q.
    // ------------------------------------------------------------------
    logic [1:0] la_q, la_d, lb_q, lb_d;

    always_comb begin
        la_d = L_RED;
        lb_d = L_RED;
        case (state_d)
            A_GREEN:  la_d = L_GRN;
            A_YELLOW: la_d = L_YEL;
            B_GREEN:  lb_d = L_GRN;
            B_YELLOW: lb_d = L_YEL;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            la_q <= L_GRN;
            lb_q <= L_RED;
        end else begin
            la_q <= la_d;
            lb_q <= lb_d;
        end
    end

    assign la    = la_q;
    assign lb    = lb_q;
    assign state = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
module tb_intersection_scheduler;

    localparam int TDIV = 4;
    localparam int GMIN = 2;
    localparam int GMAX = 5;
    localparam int YT   = 1;
    localparam int RT   = 1;
    localparam int WT   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ta = 1'b0;
    logic       tb = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] la, lb;
    logic       tick;
    logic [2:0] state;
    logic       walk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    intersection_scheduler #(
        .TICK_DIV(TDIV), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_T(YT), .ALLRED_T(RT), .WALK_T(WT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ta(ta),
        .tb(tb),
`ifdef PED_CROSS_EN
        .ped_req(ped_req),
        .walk(walk),
`endif
        .la(la),
        .lb(lb),
        .tick(tick),
        .state(state)
    );

`ifndef PED_CROSS_EN
    assign walk = 1'b0;
`endif

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. It tracks the phase number and how many ticks have
    // passed in that phase. The inputs are seen through a two-edge delay.
    // ------------------------------------------------------------------
    int m_st = 0;
    int m_n = 0;
    int m_cyc = 0;
    bit m_pend = 1'b0;
    bit m_from_b = 1'b0;
    bit ha1 = 0, ha2 = 0, hb1 = 0, hb2 = 0, hp1 = 0, hp2 = 0;

    task automatic model_step();
        bit sa, sb, sp, tk;
        int n, nx;
        sa = ha2; sb = hb2; sp = hp2;
        ha2 = ha1; ha1 = ta;
        hb2 = hb1; hb1 = tb;
        hp2 = hp1; hp1 = ped_req;
        tk = ((m_cyc % TDIV) == TDIV - 1);
        nx = m_st;
        if (tk) begin
            n = m_n + 1;
            case (m_st)
                0: if (n >= GMIN && (sb || m_pend) && (!sa || n >= GMAX)) nx = 1;
                1: if (n >= YT) nx = 2;
                2: if (n >= RT) nx = m_pend ? 6 : 3;
                3: if (n >= GMIN && (sa || m_pend) && (!sb || n >= GMAX)) nx = 4;
                4: if (n >= YT) nx = 5;
                5: if (n >= RT) nx = m_pend ? 6 : 0;
                6: if (n >= WT) nx = m_from_b ? 0 : 3;
                default: nx = 0;
            endcase
        end
        if (nx != m_st) begin
            m_n = 0;
            if (nx == 6) m_from_b = (m_st == 5);
        end else if (tk) begin
            m_n = m_n + 1;
        end
        if (nx == 6 && m_st != 6) m_pend = 1'b0;
        else if (sp)              m_pend = 1'b1;
        m_st  = nx;
        m_cyc = m_cyc + 1;
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_st = 0; m_n = 0; m_cyc = 0; m_pend = 0; m_from_b = 0;
            ha1 = 0; ha2 = 0; hb1 = 0; hb2 = 0; hp1 = 0; hp2 = 0;
        end else begin
            model_step();
        end
    end

    function automatic logic [1:0] la_of(input int s);
        case (s)
            0: return 2'b00;
            1: return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] lb_of(input int s);
        case (s)
            3: return 2'b00;
            4: return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Per-cycle comparison against the model, plus the lamp safety rule
    initial forever begin
        logic [8:0] exp_v, act_v;
        logic       exp_tick;
        @(negedge clk);
        if (chk_en) begin
            exp_tick = reset && ((m_cyc % TDIV) == TDIV - 1);
            exp_v = {3'(m_st), la_of(m_st), lb_of(m_st), exp_tick, (m_st == 6)};
            act_v = {state, la, lb, tick, walk};
            n_chk++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t {state,la,lb,tick,walk} dut=%b model=%b",
                         $time, act_v, exp_v);
            end
            n_chk++;
            if (la != 2'b10 && lb != 2'b10) begin
                n_fail++;
                $display("FAIL both_nonred t=%0t la=%b lb=%b required one red", $time, la, lb);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset(input bit a, input bit b);
        @(negedge clk);
        reset = 1'b0; ta = a; tb = b; ped_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits until the given number of edges have passed since reset release.
    task automatic wait_cyc(input int e);
        int g;
        g = 0;
        while (m_cyc < e && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (m_cyc < e) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_cyc: reached %0d required %0d", m_cyc, e);
        end
    endtask

    typedef struct { bit a; bit b; int len; } seg_t;
    seg_t segs[8] = '{
        '{1'b1, 1'b0, 30}, '{1'b0, 1'b1, 50}, '{1'b1, 1'b0, 17}, '{1'b1, 1'b1, 90},
        '{1'b0, 1'b0, 40}, '{1'b0, 1'b1, 13}, '{1'b1, 1'b1, 3},  '{1'b0, 1'b0, 60}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        chk_en = 1'b1;

        // Idle: tick timing after release, then hold A_GREEN with no demand
        do_reset(1'b0, 1'b0);
        chk("reset_state", int'(state), 0);
        chk("reset_la", int'(la), 0);
        chk("reset_lb", int'(lb), 2);
        wait_cyc(1); chk("tick_c1", int'(tick), 0);
        wait_cyc(2); chk("tick_c2", int'(tick), 0);
        wait_cyc(3); chk("tick_c3", int'(tick), 1);
        wait_cyc(4); chk("tick_c4", int'(tick), 0);
        wait_cyc(100);
        chk("idle_state", int'(state), 0);
        chk("idle_la", int'(la), 0);

        // Demand on B only
        do_reset(1'b0, 1'b1);
        wait_cyc(7);  chk("b_dem_c7", int'(state), 0);
        wait_cyc(8);  chk("b_dem_c8", int'(state), 1);
        wait_cyc(12); chk("b_dem_c12", int'(state), 2);
        wait_cyc(16); chk("b_dem_c16", int'(state), 3);
        chk("b_dem_la", int'(la), 2);
        chk("b_dem_lb", int'(lb), 0);

        // Asynchronous reset in the middle of B_GREEN
        wait_cyc(18);
        chk("pre_rst_state", int'(state), 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_la", int'(la), 0);
        chk("async_rst_lb", int'(lb), 2);
        chk("async_rst_tick", int'(tick), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_cyc(3); chk("rel_tick_c3", int'(tick), 1);
        wait_cyc(7); chk("rel_full_green_c7", int'(state), 0);
        wait_cyc(8); chk("rel_full_green_c8", int'(state), 1);

        // Both streets contested: every green runs the full GREEN_MAX
        do_reset(1'b1, 1'b1);
        wait_cyc(19); chk("both_c19", int'(state), 0);
        wait_cyc(20); chk("both_c20", int'(state), 1);
        wait_cyc(24); chk("both_c24", int'(state), 2);
        wait_cyc(28); chk("both_c28", int'(state), 3);
        wait_cyc(47); chk("both_c47", int'(state), 3);
        wait_cyc(48); chk("both_c48", int'(state), 4);
        wait_cyc(52); chk("both_c52", int'(state), 5);
        wait_cyc(56); chk("both_c56", int'(state), 0);
        wait_cyc(75); chk("both_c75", int'(state), 0);
        wait_cyc(76); chk("both_c76", int'(state), 1);

        // Mixed traffic segments, checked cycle by cycle against the model
        do_reset(1'b0, 1'b0);
        foreach (segs[i]) begin
            ta = segs[i].a;
            tb = segs[i].b;
            repeat (segs[i].len) @(negedge clk);
        end

`ifdef PED_CROSS_EN
        // Pedestrian press during A_GREEN with no traffic
        do_reset(1'b0, 1'b0);
        wait_cyc(1); ped_req = 1'b1;
        wait_cyc(2); ped_req = 1'b0;
        wait_cyc(7);  chk("ped_c7", int'(state), 0);
        wait_cyc(8);  chk("ped_c8", int'(state), 1);
        wait_cyc(12); chk("ped_c12", int'(state), 2);
        wait_cyc(16); chk("ped_c16", int'(state), 6);
        chk("ped_walk_on", int'(walk), 1);
        chk("ped_walk_la", int'(la), 2);
        chk("ped_walk_lb", int'(lb), 2);
        wait_cyc(23); chk("ped_c23", int'(state), 6);
        wait_cyc(24); chk("ped_c24", int'(state), 3);
        chk("ped_walk_off", int'(walk), 0);
        chk("ped_after_lb", int'(lb), 0);
        // Press from B_GREEN, then press again during the walk to re-arm
        wait_cyc(40); ped_req = 1'b1;
        wait_cyc(41); ped_req = 1'b0;
        wait_cyc(44); chk("ped2_c44", int'(state), 4);
        wait_cyc(52); chk("ped2_c52", int'(state), 6);
        wait_cyc(54); ped_req = 1'b1;
        wait_cyc(55); ped_req = 1'b0;
        wait_cyc(60); chk("ped2_c60", int'(state), 0);
        wait_cyc(68); chk("ped2_c68", int'(state), 1);
        wait_cyc(76); chk("ped2_c76", int'(state), 6);
        wait_cyc(84); chk("ped2_c84", int'(state), 3);
        wait_cyc(100);
`endif

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
